flags_status_unit: RTL and testbench

- Consumer end of the ALU flag interface: captures the 4-bit {N,Z,V,C} flags bus produced by the ALU operation blocks into a status register.
- Evaluates 4-bit branch/predication condition codes against the registered flags.
- Provides a small save/restore stack so flags survive exception or interrupt entry and return.
- Sits between the ALU flag outputs and the control unit's branch/predicate logic.

---
 rtl/flags_status_unit.sv | 151 +++++++++++++++
 tb/tb_flags_status_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/flags_status_unit.sv
// flags_status_unit
// Captures the ALU {N,Z,V,C} flags into a status register, evaluates branch
// condition codes against the registered flags, and keeps a small LIFO of
// saved flags for exception/interrupt entry and return.

module flags_status_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       flags_n_z_v_c,
    input  logic             flags_we,
    input  logic             push,
    input  logic             pop,
    input  logic [3:0]       cond,
    output logic             cond_pass,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] depth_count,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [3:0]       flags_r;
    logic [CNT_W-1:0] depth_r;
    logic             err_r;
    logic [3:0]       stack_r [0:DEPTH-1];

    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             load_s;
    logic             err_set_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_s;

    // Branch/predicate condition decode against a flags nibble {N,Z,V,C}.
    function automatic logic eval_cond(input logic [3:0] f, input logic [3:0] c);
        logic n_v;
        logic z_v;
        logic v_v;
        logic c_v;
        logic res_v;
        n_v = f[3];
        z_v = f[2];
        v_v = f[1];
        c_v = f[0];
        case (c)
            4'h0:    res_v = z_v;
            4'h1:    res_v = ~z_v;
            4'h2:    res_v = c_v;
            4'h3:    res_v = ~c_v;
            4'h4:    res_v = n_v;
            4'h5:    res_v = ~n_v;
            4'h6:    res_v = v_v;
            4'h7:    res_v = ~v_v;
            4'h8:    res_v = c_v & ~z_v;
            4'h9:    res_v = ~c_v | z_v;
            4'hA:    res_v = (n_v == v_v);
            4'hB:    res_v = (n_v != v_v);
            4'hC:    res_v = ~z_v & (n_v == v_v);
            4'hD:    res_v = z_v | (n_v != v_v);
            4'hE:    res_v = 1'b1;
            4'hF:    res_v = 1'b0;
            default: res_v = 1'b0;
        endcase
        return res_v;
    endfunction

    assign full_s   = (depth_r == DEPTH_C);
    assign empty_s  = (depth_r == {CNT_W{1'b0}});
    assign wr_idx_s = depth_r[IDX_W-1:0];
    assign rd_idx_s = wr_idx_s - IDX_W'(1);

    // Resolve push/pop/load interactions and stack error conditions.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        load_s    = 1'b0;
        err_set_s = 1'b0;
        if (push && pop) begin
            // Simultaneous save and restore cancel out; only the load matters.
            load_s = flags_we;
        end else if (push) begin
            if (full_s) begin
                err_set_s = 1'b1;
            end else begin
                push_ok_s = 1'b1;
            end
            load_s = flags_we;
        end else if (pop) begin
            // A pop owns the status register this cycle, even when it fails.
            if (empty_s) begin
                err_set_s = 1'b1;
            end else begin
                pop_ok_s = 1'b1;
            end
            load_s = 1'b0;
        end else begin
            load_s = flags_we;
        end
    end

    // Status register, stack depth and sticky error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= 4'b0000;
            depth_r <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            if (pop_ok_s) begin
                flags_r <= stack_r[rd_idx_s];
            end else if (load_s) begin
                flags_r <= flags_n_z_v_c;
            end else begin
                flags_r <= flags_r;
            end

            if (push_ok_s) begin
                depth_r <= depth_r + ONE_C;
            end else if (pop_ok_s) begin
                depth_r <= depth_r - ONE_C;
            end else begin
                depth_r <= depth_r;
            end

            err_r <= err_r | err_set_s;
        end
    end

    // Stack storage; contents are meaningless after reset so no reset here.
    always_ff @(posedge clk) begin
        if (push_ok_s && !rst) begin
            stack_r[wr_idx_s] <= flags_r;
        end
    end

    assign cond_pass   = eval_cond(flags_r, cond);
    assign flags_q     = flags_r;
    assign depth_count = depth_r;
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign stack_err   = err_r;

endmodule

// File: tb/tb_flags_status_unit.sv
// Self-checking bench for flags_status_unit: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.

module tb_flags_status_unit;

    localparam int DEPTH = 4;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       flags_n_z_v_c;
    logic             flags_we;
    logic             push;
    logic             pop;
    logic [3:0]       cond;
    logic             cond_pass;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] depth_count;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [3:0] m_flags;
    logic [3:0] m_stack [$];
    logic       m_err;

    logic [15:0] sweep_exp;

    always #5 clk = ~clk;

    flags_status_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flags_n_z_v_c (flags_n_z_v_c),
        .flags_we      (flags_we),
        .push          (push),
        .pop           (pop),
        .cond          (cond),
        .cond_pass     (cond_pass),
        .flags_q       (flags_q),
        .depth_count   (depth_count),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .stack_err     (stack_err)
    );

    // Even codes test a predicate, odd codes test its complement.
    function automatic logic model_cond(input logic [3:0] f, input logic [3:0] c);
        logic n, z, v, cy, base;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic we, input logic ps,
                                input logic pp, input logic [3:0] d);
        if (r) begin
            m_flags = 4'b0000;
            m_stack.delete();
            m_err = 1'b0;
        end else if (ps && pp) begin
            if (we) m_flags = d;
        end else if (ps) begin
            if (m_stack.size() == DEPTH) m_err = 1'b1;
            else m_stack.push_back(m_flags);
            if (we) m_flags = d;
        end else if (pp) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else m_flags = m_stack.pop_back();
        end else if (we) begin
            m_flags = d;
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic r, input logic we, input logic ps, input logic pp,
                        input logic [3:0] d, input logic [3:0] c);
        rst = r; flags_we = we; push = ps; pop = pp; flags_n_z_v_c = d; cond = c;
        @(negedge clk);
        check("flags_q",   32'(flags_q),     32'(m_flags));
        check("depth",     32'(depth_count), 32'(m_stack.size()));
        check("full",      32'(stack_full),  32'(m_stack.size() == DEPTH));
        check("empty",     32'(stack_empty), 32'(m_stack.size() == 0));
        check("err",       32'(stack_err),   32'(m_err));
        check("cond_pass", 32'(cond_pass),   32'(model_cond(m_flags, c)));
        @(posedge clk);
        model_update(r, we, ps, pp, d);
        #1;
    endtask

    initial begin
        rst = 1'b1; flags_we = 1'b0; push = 1'b0; pop = 1'b0;
        flags_n_z_v_c = 4'b0000; cond = 4'h0;
        m_flags = 4'b0000; m_err = 1'b0;
        sweep_exp = 16'b0101_0110_1010_1010; // bit i = expected cond_pass for code i
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state and condition sweep with flags 0000
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'(i));
            check("sweep", 32'(cond_pass), 32'(sweep_exp[i]));
        end
        check("rst_empty", 32'(stack_empty), 32'd1);
        check("rst_err",   32'(stack_err),   32'd0);

        // Write Z; condition sees it only next cycle
        rst = 1'b0; flags_we = 1'b1; flags_n_z_v_c = 4'b0100; cond = 4'h0;
        #1;
        check("we_same_cycle", 32'(cond_pass), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 4'h0);
        check("we_flags", 32'(flags_q),   32'h4);
        check("we_eq",    32'(cond_pass), 32'd1);

        // Exception entry/return: push with load, then pop
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, 4'hA);
        check("ld1001", 32'(flags_q), 32'h9);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 4'hA);
        check("pushld_flags", 32'(flags_q),     32'h2);
        check("pushld_depth", 32'(depth_count), 32'd1);
        check("pushld_ge",    32'(cond_pass),   32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 4'hA);
        check("pop_flags", 32'(flags_q),     32'h9);
        check("pop_depth", 32'(depth_count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'hB);
        check("pop_lt", 32'(cond_pass), 32'd1);

        // Fill past capacity then drain
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'h0);
        for (int k = 1; k <= DEPTH + 1; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'(k), 4'hE);
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'hE);
            if (k == DEPTH) check("full_after4", 32'(stack_full), 32'd1);
        end
        check("ovf_err",   32'(stack_err),   32'd1);
        check("ovf_depth", 32'(depth_count), 32'(DEPTH));
        for (int k = DEPTH; k >= 1; k--) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'hE);
            check("drain", 32'(flags_q), 32'(k));
        end
        check("drain_empty", 32'(stack_empty), 32'd1);
        check("drain_err",   32'(stack_err),   32'd1);

        // Underflow with a dropped load, then reset clears error
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 4'h0);
        check("unf_flags", 32'(flags_q),   32'h3);
        check("unf_err",   32'(stack_err), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'h0);
        check("rst_err_clr", 32'(stack_err), 32'd0);
        check("rst_flags",   32'(flags_q),   32'h0);

        // Push+pop together, then reset mid-stack
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 4'h0);
        check("pp_depth", 32'(depth_count), 32'd2);
        check("pp_flags", 32'(flags_q),     32'h6);
        check("pp_err",   32'(stack_err),   32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'h0);
        check("pp_depth3", 32'(depth_count), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b1010, 4'h0);
        check("rst_depth", 32'(depth_count), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 79) == 0),
                 1'($urandom),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0),
                 4'($urandom),
                 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
